// File: rtl/tt_um_sumador8bits.sv
// Tiny Tapeout tile: 8-bit adder-based up/down counter with clear, load and enable.
// Bidirectional pins are all inputs and carry the parallel load value.
module tt_um_sumador8bits #(
    parameter int WIDTH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_next;
    logic             w_en;
    logic             w_dir;
    logic             w_load;
    logic             w_clr;
    logic             w_unused;

    assign w_en   = ui_in[0];
    assign w_dir  = ui_in[1];
    assign w_load = ui_in[2];
    assign w_clr  = ui_in[3];

    // ena and the reserved control bits deliberately have no effect on the count.
    assign w_unused = &{1'b0, ena, ui_in[7:4]};

    always_comb begin
        w_next = r_count;
        if (w_clr) begin
            w_next = '0;
        end else if (w_load) begin
            w_next = uio_in[WIDTH-1:0];
        end else if (w_en) begin
            if (w_dir) begin
                w_next = r_count - WIDTH'(1);
            end else begin
                w_next = r_count + WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else begin
            r_count <= w_next;
        end
    end

    assign uo_out  = r_count;
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_tt_um_sumador8bits.sv
// Directed self-checking bench for the tt_um_sumador8bits counter tile.
// Reserved ui_in bits toggle every cycle and ena stays low for the whole run.
module tb_tt_um_sumador8bits;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int         vectorCount;
    int         errorCount;
    logic [3:0] reservedPattern;

    tt_um_sumador8bits dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ena    (ena),
        .ui_in  (ui_in),
        .uo_out (uo_out),
        .uio_in (uio_in),
        .uio_out(uio_out),
        .uio_oe (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %02h, expected %02h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic checkPins(input string tag);
        checkOutput({tag, "_uio_out"}, uio_out, 8'h00);
        checkOutput({tag, "_uio_oe"}, uio_oe, 8'h00);
    endtask

    // Drive one cycle of controls, let the edge happen, and return 1 time unit after it.
    task automatic applyStimulus(input logic [3:0] ctrl, input logic [7:0] loadValue);
        ui_in  = {reservedPattern, ctrl};
        uio_in = loadValue;
        @(posedge clk);
        #1;
        reservedPattern = reservedPattern + 4'h7;
    endtask

    // Pull reset low between edges, confirm the asynchronous clear, then release on a falling edge.
    task automatic pulseReset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput({tag, "_async"}, uo_out, 8'h00);
        checkPins({tag, "_inreset"});
        ui_in = {reservedPattern, 4'h1};
        @(posedge clk);
        #1;
        checkOutput({tag, "_held"}, uo_out, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(4'h0, 8'h00);
        checkOutput({tag, "_after"}, uo_out, 8'h00);
    endtask

    initial begin
        vectorCount     = 0;
        errorCount      = 0;
        reservedPattern = 4'h0;
        ena             = 1'b0;
        ui_in           = 8'h00;
        uio_in          = 8'h00;
        rst_n           = 1'b1;

        #1;
        rst_n = 1'b0;
        #2;
        checkOutput("reset_initial", uo_out, 8'h00);
        checkPins("reset_initial");
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(4'h0, 8'h00);
        checkOutput("reset_release", uo_out, 8'h00);

        for (int i = 1; i <= 10; i++) begin
            applyStimulus(4'h1, 8'h00);
            checkOutput($sformatf("count_up_%0d", i), uo_out, 8'(i));
        end

        pulseReset("reset_a");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(4'h0, 8'hC3);
            checkOutput($sformatf("idle_%0d", i), uo_out, 8'h00);
        end
        for (int i = 0; i < 3; i++) applyStimulus(4'h1, 8'h00);
        checkOutput("count_three", uo_out, 8'h03);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(4'h0, 8'h99);
            checkOutput($sformatf("hold_%0d", i), uo_out, 8'h03);
        end

        ui_in  = {reservedPattern, 4'h4};
        uio_in = 8'hAA;
        #2;
        checkOutput("no_comb_path", uo_out, 8'h03);

        applyStimulus(4'h4, 8'hFE);
        checkOutput("load_fe", uo_out, 8'hFE);
        applyStimulus(4'h1, 8'h00);
        checkOutput("wrap_up_ff", uo_out, 8'hFF);
        applyStimulus(4'h1, 8'h00);
        checkOutput("wrap_up_00", uo_out, 8'h00);
        applyStimulus(4'h1, 8'h00);
        checkOutput("wrap_up_01", uo_out, 8'h01);
        checkPins("mid_run");

        applyStimulus(4'h4, 8'h01);
        checkOutput("load_01", uo_out, 8'h01);
        applyStimulus(4'h3, 8'h00);
        checkOutput("wrap_down_00", uo_out, 8'h00);
        applyStimulus(4'h3, 8'h00);
        checkOutput("wrap_down_ff", uo_out, 8'hFF);
        applyStimulus(4'h3, 8'h00);
        checkOutput("wrap_down_fe", uo_out, 8'hFE);

        applyStimulus(4'hF, 8'h55);
        checkOutput("prio_clr", uo_out, 8'h00);
        applyStimulus(4'h7, 8'h55);
        checkOutput("prio_load", uo_out, 8'h55);
        applyStimulus(4'h2, 8'h12);
        checkOutput("dir_without_en", uo_out, 8'h55);

        applyStimulus(4'h8, 8'h00);
        for (int i = 0; i < 32; i++) applyStimulus(4'h1, 8'h00);
        checkOutput("count_to_20", uo_out, 8'h20);
        pulseReset("reset_mid");
        applyStimulus(4'h1, 8'h00);
        checkOutput("resume_after_reset", uo_out, 8'h01);
        checkPins("end_run");

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, errorCount);
        $finish;
    end

endmodule
